// File: rtl/mult_hilo_ctrl.sv
// HI/LO register controller for an external combinational 64-bit multiplier.
// It launches a MULT, waits LATENCY cycles, then captures the product into HI/LO.
// MTHI/MTLO write HI or LO directly when the block is idle.
module mult_hilo_ctrl #(
    parameter int unsigned LATENCY = 4
) (
    input  logic        CLK,
    input  logic        Clear,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] MulA,
    output logic [31:0] MulB,
    input  logic [63:0] Product,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Done,
    output logic        Reject
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_MTHI = 2'b01;
    localparam logic [1:0] OP_MTLO = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [DATA_W-1:0]   mul_a_nxt;
    logic [DATA_W-1:0]   mul_b_nxt;
    logic [DATA_W-1:0]   hi_nxt;
    logic [DATA_W-1:0]   lo_nxt;
    logic                busy_nxt;
    logic                done_nxt;
    logic                reject_nxt;

    // State, counter and all registered outputs; Clear forces everything to zero at once.
    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear) begin
            state  <= S_IDLE;
            cnt    <= '0;
            MulA   <= '0;
            MulB   <= '0;
            HI     <= '0;
            LO     <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Reject <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            MulA   <= mul_a_nxt;
            MulB   <= mul_b_nxt;
            HI     <= hi_nxt;
            LO     <= lo_nxt;
            Busy   <= busy_nxt;
            Done   <= done_nxt;
            Reject <= reject_nxt;
        end
    end

    // Next-state and next-output decode; Done/Reject default low so they pulse one cycle.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        mul_a_nxt  = MulA;
        mul_b_nxt  = MulB;
        hi_nxt     = HI;
        lo_nxt     = LO;
        busy_nxt   = Busy;
        done_nxt   = 1'b0;
        reject_nxt = 1'b0;

        case (state)
            S_IDLE: begin
                if (Start) begin
                    case (Op)
                        OP_MULT: begin
                            mul_a_nxt = A;
                            mul_b_nxt = B;
                            cnt_nxt   = CNT_LOAD;
                            busy_nxt  = 1'b1;
                            state_nxt = S_WAIT;
                        end
                        OP_MTHI: hi_nxt = A;
                        OP_MTLO: lo_nxt = A;
                        default: ;
                    endcase
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - CNT_ONE;
                // Any real request while a MULT is in flight is refused, including on the capture edge.
                if (Start && (Op != OP_NOP)) begin
                    reject_nxt = 1'b1;
                end
                if (cnt == CNT_ONE) begin
                    hi_nxt    = Product[63:32];
                    lo_nxt    = Product[31:0];
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule
